// File: rtl/priority_seq_fsm.sv
// Four-state priority sequencer (IDLE/RUN/MIDDLE/LAST) with a configurable select
// decode, a LAST dwell length and an optional RUN timeout.
module priority_seq_fsm #(
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned SEL_IDLE    = 2,
    parameter int unsigned SEL_LAST    = 3,
    parameter int unsigned LAST_LEN    = 1,
    parameter int unsigned RUN_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [SEL_W-1:0] sel,
    output logic             f,
    output logic             timeout,
    output logic             busy,
    output logic [1:0]       state_o
);

    localparam int unsigned CNT_MAX = (LAST_LEN > RUN_TIMEOUT) ? LAST_LEN : RUN_TIMEOUT;
    localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]    LAST_END = CW'(LAST_LEN - 1);
    localparam logic [CW-1:0]    RUN_END  = CW'((RUN_TIMEOUT == 0) ? 0 : RUN_TIMEOUT - 1);
    localparam logic [SEL_W-1:0] SEL_I    = SEL_W'(SEL_IDLE);
    localparam logic [SEL_W-1:0] SEL_L    = SEL_W'(SEL_LAST);
    localparam bit               TO_EN    = (RUN_TIMEOUT != 0);

    generate
        if (LAST_LEN == 0) begin : g_bad_last_len
            $error("priority_seq_fsm: LAST_LEN must be at least 1");
        end
        if ((64'(SEL_IDLE) >> SEL_W) != 0 || (64'(SEL_LAST) >> SEL_W) != 0) begin : g_bad_sel
            $error("priority_seq_fsm: SEL_IDLE/SEL_LAST do not fit in SEL_W bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAST   = 2'd2,
        MIDDLE = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] run_cnt, run_cnt_nx;
    logic [CW-1:0] last_cnt, last_cnt_nx;
    logic          timeout_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_cnt  <= '0;
            last_cnt <= '0;
            f        <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            run_cnt  <= run_cnt_nx;
            last_cnt <= last_cnt_nx;
            f        <= (state == LAST);
            timeout  <= timeout_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        run_cnt_nx  = run_cnt;
        last_cnt_nx = last_cnt;
        timeout_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nx   = RUN;
                    run_cnt_nx = '0;
                end
            end
            RUN: begin
                // go=0 outranks the timeout exit, so a coincident drop gives no pulse
                if (!go) begin
                    state_nx = MIDDLE;
                end else if (TO_EN && run_cnt == RUN_END) begin
                    state_nx   = MIDDLE;
                    timeout_nx = 1'b1;
                end else if (run_cnt != '1) begin
                    run_cnt_nx = run_cnt + CW'(1);
                end
            end
            MIDDLE: begin
                if (go) begin
                    state_nx   = RUN;
                    run_cnt_nx = '0;
                end else if (sel == SEL_I) begin
                    state_nx = IDLE;
                end else if (sel == SEL_L) begin
                    state_nx    = LAST;
                    last_cnt_nx = '0;
                end
            end
            LAST: begin
                if (last_cnt == LAST_END) begin
                    state_nx = IDLE;
                end else if (last_cnt != '1) begin
                    last_cnt_nx = last_cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign state_o = state;

endmodule
